// File: rtl/binary_to_bcd.sv
// binary_to_bcd: registered 32-bit binary to two-digit packed BCD with >99 flag
module binary_to_bcd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bin,
  output logic [7:0]  bcd,
  output logic        ovf
);
  logic [71:0] sr;
  // full double-dabble over all 32 bits, ten 4-bit digits land in sr[71:32]
  always_comb begin
    sr = {40'd0, bin};
    for (int i = 0; i < 32; i++) begin
      for (int d = 0; d < 10; d++)
        sr[32+4*d +: 4] = sr[32+4*d +: 4] >= 4'd5 ? sr[32+4*d +: 4] + 4'd3 : sr[32+4*d +: 4];
      sr = sr << 1;
    end
  end
  // single output register; async clear discards any in-flight value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd <= 8'h00;
      ovf <= 1'b0;
    end else begin
      bcd <= sr[39:32];
      ovf <= |sr[71:40];
    end
  end
endmodule

// File: tb/tb_binary_to_bcd.sv
// tb_binary_to_bcd: directed and random checks of the registered binary to BCD converter
module tb_binary_to_bcd;
  logic        clk;
  logic        rst_n;
  logic [31:0] bin;
  logic [7:0]  bcd;
  logic        ovf;
  int n_checks = 0;
  int n_fail = 0;

  binary_to_bcd dut (.clk(clk), .rst_n(rst_n), .bin(bin), .bcd(bcd), .ovf(ovf));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply(input string tag, input logic [31:0] v, input logic [7:0] eb, input logic eo);
    @(negedge clk);
    bin = v;
    @(posedge clk);
    #1;
    check({tag, "_bcd"}, {24'd0, bcd}, {24'd0, eb});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] u;
    logic [31:0] t;
    rst_n = 1'b1;
    bin = 32'd0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_bcd", {24'd0, bcd}, 32'h0);
    check("rst_ovf", {31'd0, ovf}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("b99", 32'd99, 8'h99, 1'b0);
    apply("b46", 32'd46, 8'h46, 1'b0);
    apply("b53", 32'd53, 8'h53, 1'b0);
    apply("b0", 32'd0, 8'h00, 1'b0);
    apply("b9", 32'd9, 8'h09, 1'b0);
    apply("b10", 32'd10, 8'h10, 1'b0);
    apply("b100", 32'd100, 8'h00, 1'b1);
    apply("b199", 32'd199, 8'h99, 1'b1);
    apply("bmax", 32'hFFFFFFFF, 8'h95, 1'b1);
    apply("b123456789", 32'd123456789, 8'h89, 1'b1);
    // latency: output changes only on rising edges
    apply("lat46", 32'd46, 8'h46, 1'b0);
    @(negedge clk);
    bin = 32'd53;
    #3;
    check("lat_hold", {24'd0, bcd}, 32'h46);
    @(posedge clk);
    #1;
    check("lat53", {24'd0, bcd}, 32'h53);
    // reset mid-stream
    apply("pre_rst", 32'd99, 8'h99, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_bcd", {24'd0, bcd}, 32'h0);
    check("async_ovf", {31'd0, ovf}, 32'h0);
    bin = 32'd146;
    @(posedge clk);
    #1;
    check("hold_bcd", {24'd0, bcd}, 32'h0);
    check("hold_ovf", {31'd0, ovf}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_bcd", {24'd0, bcd}, 32'h46);
    check("rel_ovf", {31'd0, ovf}, 32'h1);
    // random against reference model
    for (int i = 0; i < 10000; i++) begin
      v = $urandom;
      if (i % 4 == 0) v = v % 1000;
      u = v % 10;
      t = (v / 10) % 10;
      @(negedge clk);
      bin = v;
      @(posedge clk);
      #1;
      check("rnd_units", {28'd0, bcd[3:0]}, u);
      check("rnd_tens", {28'd0, bcd[7:4]}, t);
      check("rnd_ovf", {31'd0, ovf}, {31'd0, v > 32'd99});
      check("rnd_nib_ok", {31'd0, bcd[3:0] <= 4'd9 && bcd[7:4] <= 4'd9}, 32'd1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
